// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: start bit, DBIT data bits LSB first, optional even parity, stop period.
// Paced by the 16x oversample tick. Gates the baud generator through baud_enable.
module uart_tx_controller #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int PARITY_EN = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    input  logic            s_tick,
    output logic            baud_enable,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int S_W = (SB_TICK > 16) ? 5 : 4;
    localparam int N_W = $clog2(DBIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q;
    logic [S_W-1:0]  s_q;
    logic [N_W-1:0]  n_q;
    logic [DBIT-1:0] b_q;
    logic            par_q;
    logic            tx_q;
    logic            busy_q;
    logic            baud_q;
    logic            done_q;

    // Every output is loaded on the edge that changes the state, so tx has no
    // combinational path from any input.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift register is cleared along with the control state, so an abandoned
            // frame leaves nothing behind; non-blocking updates let each branch read the old b_q.
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            baud_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_start) begin
                        b_q     <= tx_din;
                        par_q   <= ^tx_din;
                        s_q     <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        baud_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == S_W'(15)) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            tx_q    <= b_q[0];
                            state_q <= DATA;
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == S_W'(15)) begin
                            s_q <= '0;
                            b_q <= b_q >> 1;
                            if (n_q == N_W'(DBIT - 1)) begin
                                if (PARITY_EN != 0) begin
                                    tx_q    <= par_q;
                                    state_q <= PARITY;
                                end else begin
                                    tx_q    <= 1'b1;
                                    state_q <= STOP;
                                end
                            end else begin
                                n_q  <= n_q + N_W'(1);
                                tx_q <= b_q[1];
                            end
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s_q == S_W'(15)) begin
                            s_q     <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_q == S_W'(SB_TICK - 1)) begin
                            s_q     <= '0;
                            busy_q  <= 1'b0;
                            baud_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    baud_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign baud_enable  = baud_q;
    assign tx_done_tick = done_q;

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
- Frame-sequencing FSM for the UART transmit path.
- Consumes the 16x-oversample tick from the baud-rate generator and gates that generator through baud_enable.
- Serialises one parallel word per request: start bit, DBIT data bits LSB first, optional even parity bit, stop period.
- Sits between the TX FIFO/host logic and the tx pin.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, stop-period length in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tx_start  input  1  request to send tx_din; sampled only in IDLE
tx_din  input  DBIT  word to transmit; sampled in the cycle tx_start is accepted
s_tick  input  1  one-clk pulse from the baud generator, 16 per bit period
baud_enable  output  1  enable for the baud generator; high while a frame is in progress
tx  output  1  serial line, idle high, registered
tx_busy  output  1  high from acceptance until the end of the stop period
tx_done_tick  output  1  one-clk pulse at frame completion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: state=IDLE, tx=1, tx_busy=0, baud_enable=0, tx_done_tick=0. Tick counter s, bit counter n and shift register b cleared.
- Reset asserted mid-frame: the next edge forces the reset values. No tx_done_tick. The partial frame is abandoned.
- Internal storage: s (4 bits; 5 bits if SB_TICK>16), n (ceil(log2(DBIT)) bits), b (DBIT bits), par (1 bit).
- tx, tx_busy, baud_enable and tx_done_tick are registers that update on the same edge as the state register. No combinational path from inputs to tx.
- IDLE:
  - tx=1.
  - tx_start=1: b<=tx_din, par<=^tx_din, s<=0, go to START. tx goes 0, tx_busy and baud_enable go 1 on that edge.
  - s_tick is ignored in IDLE.
- START:
  - tx=0.
  - On s_tick with s==15: s<=0, n<=0, go to DATA. Otherwise increment s on s_tick.
- DATA:
  - tx=b[0].
  - On s_tick with s==15: s<=0, b<=b>>1.
  - Then if n==DBIT-1, go to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0); else n<=n+1.
- PARITY:
  - tx=par (even parity: total count of ones over data plus parity is even).
  - On s_tick with s==15: s<=0, go to STOP.
- STOP:
  - tx=1.
  - On s_tick with s==SB_TICK-1: go to IDLE; tx_busy<=0, baud_enable<=0, tx_done_tick<=1 for exactly one clk.
- Start-bit timing: the first tick after enabling may arrive early because generator phase is not cleared. The start bit is therefore 15 to 16 tick periods; every later bit is exactly 16.
- tx_start outside IDLE: ignored. No queuing; tx_din changes have no effect mid-frame.
- Back-to-back frames: tx_start high in the cycle tx_done_tick is high (state already IDLE) is accepted. tx stays 1 for that single cycle, then the start bit begins.
- A tx_start pulse spanning multiple cycles starts exactly one frame; the remaining cycles fall outside IDLE.
- Each clk with s_tick=1 counts as one tick; the generator guarantees single-cycle pulses.
- Frame length in ticks: 16 x (1 + DBIT + PARITY_EN) + SB_TICK.

Test Plan:
- Reset check: reset=1 for 3 clks with random inputs -> tx=1, tx_busy=0, baud_enable=0, tx_done_tick=0 throughout.
- Basic frame: DBIT=8, PARITY_EN=0, s_tick every 4 clks, tx_din=0x55 with a 1-clk tx_start -> tx: 0 for 16 ticks, then 1,0,1,0,1,0,1,0 (16 ticks each), then 1 for 16 ticks. tx_done_tick single pulse at tick 160. tx_busy high for the whole frame.
- Parity frame: PARITY_EN=1, tx_din=0x07 -> parity bit 1; tx_din=0x03 -> parity bit 0. tx_done_tick at tick 176.
- Ignored start and back-to-back: tx_start with tx_din=0xFF during DATA of a 0x55 frame -> 0x55 frame unchanged. Then tx_start with tx_din=0xA3 in the tx_done_tick cycle -> start bit on the next edge, data 1,1,0,0,0,1,0,1.
- Mid-frame reset: reset pulsed while sending bit 3 of 0x55 -> next edge tx=1, tx_busy=0, baud_enable=0, no tx_done_tick. A following 0x0F frame transmits correctly.
- Two stop bits: SB_TICK=32, tx_din=0x00 -> tx high for 32 ticks after the data bits; tx_done_tick at tick 176.
